// File: rtl/id_alu_issue_if.sv
// Issue-stage bundle: fetch-side offer, regfile read port and EX-side issue bundle.
// slave is the decode stage's view; master is the environment driving it.
interface id_alu_issue_if #(
  parameter int PC_W = 32
);
  logic            flush;
  logic            fs_to_ds_valid;
  logic [31:0]     fs_inst;
  logic [PC_W-1:0] fs_pc;
  logic            ds_allowin;
  logic [4:0]      rf_raddr1;
  logic [4:0]      rf_raddr2;
  logic [31:0]     rs_value;
  logic [31:0]     rt_value;
  logic            es_allowin;
  logic            ds_to_es_valid;
  logic [PC_W-1:0] ds_pc;
  logic [11:0]     alu_op;
  logic [31:0]     alu_src1;
  logic [31:0]     alu_src2;
  logic [4:0]      dest;
  logic            ov_en;
  logic            inst_invalid;

  modport slave (
    input  flush, fs_to_ds_valid, fs_inst, fs_pc, rs_value, rt_value, es_allowin,
    output ds_allowin, rf_raddr1, rf_raddr2, ds_to_es_valid, ds_pc,
           alu_op, alu_src1, alu_src2, dest, ov_en, inst_invalid
  );

  modport master (
    output flush, fs_to_ds_valid, fs_inst, fs_pc, rs_value, rt_value, es_allowin,
    input  ds_allowin, rf_raddr1, rf_raddr2, ds_to_es_valid, ds_pc,
           alu_op, alu_src1, alu_src2, dest, ov_en, inst_invalid
  );
endinterface

// File: rtl/id_alu_issue.sv
// Decode/issue stage: holds one fetched instruction, decodes it and presents the
// one-hot ALU operation, operands, destination and overflow enable to EX.
module id_alu_issue #(
  parameter int PC_W = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  id_alu_issue_if.slave        bus
);
  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SUB  = 12'h002;
  localparam logic [11:0] OP_SLT  = 12'h004;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_AND  = 12'h010;
  localparam logic [11:0] OP_NOR  = 12'h020;
  localparam logic [11:0] OP_OR   = 12'h040;
  localparam logic [11:0] OP_XOR  = 12'h080;
  localparam logic [11:0] OP_SLL  = 12'h100;
  localparam logic [11:0] OP_SRL  = 12'h200;
  localparam logic [11:0] OP_SRA  = 12'h400;
  localparam logic [11:0] OP_LUI  = 12'h800;

  logic            ds_valid_q, ds_valid_d;
  logic [31:0]     ds_inst_q, ds_inst_d;
  logic [PC_W-1:0] ds_pc_q, ds_pc_d;
  logic            accept;

  // Handshake: a transfer happens on a rising edge where the producer's valid and
  // the consumer's allowin are both high; flush wins over any transfer into this stage.
  assign bus.ds_allowin = ~ds_valid_q | bus.es_allowin;
  assign accept         = bus.fs_to_ds_valid & bus.ds_allowin & ~bus.flush;

  always_comb begin
    ds_valid_d = ds_valid_q;
    ds_inst_d  = ds_inst_q;
    ds_pc_d    = ds_pc_q;
    if (bus.flush) begin
      ds_valid_d = 1'b0;
    end else if (bus.ds_allowin) begin
      ds_valid_d = bus.fs_to_ds_valid;
    end
    if (accept) begin
      ds_inst_d = bus.fs_inst;
      ds_pc_d   = bus.fs_pc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid_q <= 1'b0;
      ds_inst_q  <= '0;
      ds_pc_q    <= '0;
    end else begin
      ds_valid_q <= ds_valid_d;
      ds_inst_q  <= ds_inst_d;
      ds_pc_q    <= ds_pc_d;
    end
  end

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext;

  assign opcode   = ds_inst_q[31:26];
  assign rs       = ds_inst_q[25:21];
  assign rt       = ds_inst_q[20:16];
  assign rd       = ds_inst_q[15:11];
  assign sa       = ds_inst_q[10:6];
  assign funct    = ds_inst_q[5:0];
  assign imm      = ds_inst_q[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'b0, imm};

  assign bus.rf_raddr1 = rs;
  assign bus.rf_raddr2 = rt;

  logic [11:0] dec_op;
  logic [31:0] dec_src1, dec_src2;
  logic [4:0]  dec_dest;
  logic        dec_ov, dec_inv;

  always_comb begin
    dec_op   = '0;
    dec_src1 = bus.rs_value;
    dec_src2 = bus.rt_value;
    dec_dest = '0;
    dec_ov   = 1'b0;
    dec_inv  = 1'b0;
    case (opcode)
      6'h00: begin
        dec_dest = rd;
        case (funct)
          6'h20: begin dec_op = OP_ADD; dec_ov = 1'b1; end
          6'h21: dec_op = OP_ADD;
          6'h22: begin dec_op = OP_SUB; dec_ov = 1'b1; end
          6'h23: dec_op = OP_SUB;
          6'h2A: dec_op = OP_SLT;
          6'h2B: dec_op = OP_SLTU;
          6'h24: dec_op = OP_AND;
          6'h25: dec_op = OP_OR;
          6'h26: dec_op = OP_XOR;
          6'h27: dec_op = OP_NOR;
          6'h00: begin dec_op = OP_SLL; dec_src1 = {27'b0, sa}; end
          6'h02: begin dec_op = OP_SRL; dec_src1 = {27'b0, sa}; end
          6'h03: begin dec_op = OP_SRA; dec_src1 = {27'b0, sa}; end
          6'h04: dec_op = OP_SLL;
          6'h06: dec_op = OP_SRL;
          6'h07: dec_op = OP_SRA;
          default: begin dec_inv = 1'b1; dec_dest = '0; end
        endcase
      end
      6'h08: begin dec_op = OP_ADD;  dec_src2 = imm_sext; dec_dest = rt; dec_ov = 1'b1; end
      6'h09: begin dec_op = OP_ADD;  dec_src2 = imm_sext; dec_dest = rt; end
      6'h0A: begin dec_op = OP_SLT;  dec_src2 = imm_sext; dec_dest = rt; end
      6'h0B: begin dec_op = OP_SLTU; dec_src2 = imm_sext; dec_dest = rt; end
      6'h0C: begin dec_op = OP_AND;  dec_src2 = imm_zext; dec_dest = rt; end
      6'h0D: begin dec_op = OP_OR;   dec_src2 = imm_zext; dec_dest = rt; end
      6'h0E: begin dec_op = OP_XOR;  dec_src2 = imm_zext; dec_dest = rt; end
      6'h0F: begin dec_op = OP_LUI;  dec_src2 = imm_zext; dec_dest = rt; end
      6'h23: begin dec_op = OP_ADD;  dec_src2 = imm_sext; dec_dest = rt; end
      6'h2B: begin dec_op = OP_ADD;  dec_src2 = imm_sext; end
      default: dec_inv = 1'b1;
    endcase
  end

  // An empty stage presents an all-zero bundle so EX never sees stale decode.
  assign bus.ds_to_es_valid = ds_valid_q;
  assign bus.ds_pc          = ds_pc_q;
  assign bus.alu_op         = ds_valid_q ? dec_op   : '0;
  assign bus.alu_src1       = ds_valid_q ? dec_src1 : '0;
  assign bus.alu_src2       = ds_valid_q ? dec_src2 : '0;
  assign bus.dest           = ds_valid_q ? dec_dest : '0;
  assign bus.ov_en          = ds_valid_q & dec_ov;
  assign bus.inst_invalid   = ds_valid_q & dec_inv;
endmodule

// File: tb/tb_id_alu_issue.sv
// Bench for id_alu_issue: directed instructions with hand-computed bundles,
// checked by a monitor against an expected queue, plus stall/flush/reset probes.
module tb_id_alu_issue;
  localparam int PC_W = 32;
  localparam int W    = 12 + 32 + 32 + 5 + 1 + 1 + PC_W;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  id_alu_issue_if #(.PC_W(PC_W)) bus ();
  id_alu_issue #(.PC_W(PC_W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  logic [31:0] rf [32];
  assign bus.rs_value = rf[bus.rf_raddr1];
  assign bus.rt_value = rf[bus.rf_raddr2];

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [W-1:0] mk(input logic [11:0] op, input logic [31:0] s1,
                                      input logic [31:0] s2, input logic [4:0] d,
                                      input logic ov, input logic inv,
                                      input logic [PC_W-1:0] pc);
    return {op, s1, s2, d, ov, inv, pc};
  endfunction

  function automatic logic [W-1:0] actual_bundle();
    return mk(bus.alu_op, bus.alu_src1, bus.alu_src2, bus.dest, bus.ov_en,
              bus.inst_invalid, bus.ds_pc);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every handoff to EX must match the oldest expected bundle.
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (resetn === 1'b1 && bus.ds_to_es_valid === 1'b1 && bus.es_allowin === 1'b1) begin
      n_tests++;
      a = actual_bundle();
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue: unexpected bundle %h with nothing expected", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL issue pc=%h: got op=%h s1=%h s2=%h dest=%0d ov=%b inv=%b pc=%h, required op=%h s1=%h s2=%h dest=%0d ov=%b inv=%b",
                   e[PC_W-1:0], a[W-1 -: 12], a[W-13 -: 32], a[W-45 -: 32], a[W-77 -: 5],
                   a[PC_W+1], a[PC_W], a[PC_W-1:0], e[W-1 -: 12], e[W-13 -: 32],
                   e[W-45 -: 32], e[W-77 -: 5], e[PC_W+1], e[PC_W]);
        end
      end
    end
  end

  // Offer one instruction; the expected bundle is queued once fetch's offer is taken.
  task automatic offer(input logic [31:0] inst, input logic [PC_W-1:0] pc,
                       input logic [W-1:0] exp);
    bit done;
    done = 1'b0;
    bus.fs_to_ds_valid = 1'b1;
    bus.fs_inst        = inst;
    bus.fs_pc          = pc;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.ds_allowin) begin
        @(posedge clk);
        exp_q.push_back(exp);
        done = 1'b1;
      end
    end
    #1;
    bus.fs_to_ds_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL offer: pc %h not accepted within 50 cycles", pc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " valid"}, {31'b0, bus.ds_to_es_valid}, 32'd0);
    check({tag, " alu_op"}, {20'b0, bus.alu_op}, 32'd0);
    check({tag, " src1"}, bus.alu_src1, 32'd0);
    check({tag, " src2"}, bus.alu_src2, 32'd0);
    check({tag, " dest"}, {27'b0, bus.dest}, 32'd0);
    check({tag, " ov_en"}, {31'b0, bus.ov_en}, 32'd0);
    check({tag, " invalid"}, {31'b0, bus.inst_invalid}, 32'd0);
    check({tag, " ds_pc"}, bus.ds_pc, 32'd0);
    check({tag, " allowin"}, {31'b0, bus.ds_allowin}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hC000_0000 | i;
    rf[0] = 32'h0;
    rf[1] = 32'h0000_0010;
    rf[5] = 32'h8000_0000;
    bus.flush = 1'b0;
    bus.fs_to_ds_valid = 1'b0;
    bus.fs_inst = '0;
    bus.fs_pc = '0;
    bus.es_allowin = 1'b1;
    resetn = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back directed decode vectors
    offer(32'h2422FFFC, 32'h100, mk(12'h001, 32'h10,       32'hFFFFFFFC, 5'd2,  1'b0, 1'b0, 32'h100));
    offer(32'h34038000, 32'h104, mk(12'h040, 32'h0,        32'h00008000, 5'd3,  1'b0, 1'b0, 32'h104));
    offer(32'h3C031234, 32'h108, mk(12'h800, 32'h0,        32'h00001234, 5'd3,  1'b0, 1'b0, 32'h108));
    offer(32'h000520C3, 32'h10C, mk(12'h400, 32'h3,        32'h80000000, 5'd4,  1'b0, 1'b0, 32'h10C));
    offer(32'h00253020, 32'h110, mk(12'h001, 32'h10,       32'h80000000, 5'd6,  1'b1, 1'b0, 32'h110));
    offer(32'h00A13822, 32'h114, mk(12'h002, 32'h80000000, 32'h10,       5'd7,  1'b1, 1'b0, 32'h114));
    offer(32'hAC250008, 32'h118, mk(12'h001, 32'h10,       32'h8,        5'd0,  1'b0, 1'b0, 32'h118));
    offer(32'h8CADFFF8, 32'h11C, mk(12'h001, 32'h80000000, 32'hFFFFFFF8, 5'd13, 1'b0, 1'b0, 32'h11C));
    offer(32'h00000000, 32'h120, mk(12'h100, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 32'h120));
    offer(32'hFC000000, 32'h124, mk(12'h000, 32'h0,        32'h0,        5'd0,  1'b0, 1'b1, 32'h124));

    // Backpressure: hold xori while fetch offers sltu
    offer(32'h382800FF, 32'h200, mk(12'h080, 32'h10, 32'h000000FF, 5'd8, 1'b0, 1'b0, 32'h200));
    bus.es_allowin = 1'b0;
    fork
      offer(32'h0025482B, 32'h204, mk(12'h008, 32'h10, 32'h80000000, 5'd9, 1'b0, 1'b0, 32'h204));
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall allowin", {31'b0, bus.ds_allowin}, 32'd0);
          check("stall valid", {31'b0, bus.ds_to_es_valid}, 32'd1);
          check("stall alu_op", {20'b0, bus.alu_op}, 32'h080);
          check("stall src2", bus.alu_src2, 32'hFF);
          check("stall dest", {27'b0, bus.dest}, 32'd8);
          check("stall ds_pc", bus.ds_pc, 32'h200);
        end
        @(posedge clk);
        #1;
        bus.es_allowin = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Flush beats a simultaneous offer into an empty stage
    bus.flush = 1'b1;
    bus.fs_to_ds_valid = 1'b1;
    bus.fs_inst = 32'h00253020;
    bus.fs_pc = 32'h300;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.fs_to_ds_valid = 1'b0;
    check("flush+offer valid", {31'b0, bus.ds_to_es_valid}, 32'd0);
    check("flush+offer alu_op", {20'b0, bus.alu_op}, 32'd0);

    // Flush discards a held instruction
    bus.es_allowin = 1'b0;
    offer(32'h00255824, 32'h304, mk(12'h010, 32'h10, 32'h80000000, 5'd11, 1'b0, 1'b0, 32'h304));
    check("held and alu_op", {20'b0, bus.alu_op}, 32'h010);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush held valid", {31'b0, bus.ds_to_es_valid}, 32'd0);
    void'(exp_q.pop_back());

    // Asynchronous reset mid-stream, away from any clock edge
    offer(32'h00256027, 32'h308, mk(12'h020, 32'h10, 32'h80000000, 5'd12, 1'b0, 1'b0, 32'h308));
    check("held nor valid", {31'b0, bus.ds_to_es_valid}, 32'd1);
    check("held nor alu_op", {20'b0, bus.alu_op}, 32'h020);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("async reset");
    void'(exp_q.pop_back());
    @(negedge clk);
    resetn = 1'b1;
    bus.es_allowin = 1'b1;
    @(posedge clk);
    #1;
    offer(32'h00255006, 32'h400, mk(12'h200, 32'h10, 32'h80000000, 5'd10, 1'b0, 1'b0, 32'h400));
    repeat (3) @(posedge clk);
    #1;
    check("queue drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/id_alu_issue.md
Name: id_alu_issue

Overview:
- Decode/issue stage that produces the operand bundle consumed by the EX-stage ALU: one-hot alu_op, alu_src1, alu_src2, destination register and overflow-trap enable.
- Holds one instruction from fetch in a pipeline register and decodes it.
- Reads the register file and hands the result to EX under a valid/allowin handshake with backpressure and flush.

Parameters:
- PC_W, 32, width of the PC carried alongside the instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  discards the held instruction (exception/branch redirect).
- fs_to_ds_valid  in  1  fetch offers an instruction.
- fs_inst  in  32  offered instruction word.
- fs_pc  in  PC_W  PC of the offered instruction.
- ds_allowin  out  1  this stage can accept this cycle.
- rf_raddr1  out  5  regfile read address, rs field of the held instruction.
- rf_raddr2  out  5  regfile read address, rt field of the held instruction.
- rs_value  in  32  combinational regfile data for rf_raddr1.
- rt_value  in  32  combinational regfile data for rf_raddr2.
- es_allowin  in  1  EX stage can accept.
- ds_to_es_valid  out  1  issue bundle valid.
- ds_pc  out  PC_W  PC of the held instruction.
- alu_op  out  12  one-hot: [0]add [1]sub [2]slt [3]sltu [4]and [5]nor [6]or [7]xor [8]sll [9]srl [10]sra [11]lui.
- alu_src1  out  32  first ALU operand.
- alu_src2  out  32  second ALU operand.
- dest  out  5  destination register; 0 means no write.
- ov_en  out  1  EX raises an overflow exception on ALU overflow.
- inst_invalid  out  1  reserved-instruction indication.

Behaviour:
- Registers: ds_valid, ds_inst, ds_pc. On reset all are 0. ds_valid=0 forces every output low: ds_to_es_valid, alu_op, alu_src1, alu_src2, dest, ov_en, inst_invalid.
- ds_allowin = ~ds_valid | es_allowin. The stage never stalls internally.
- ds_to_es_valid = ds_valid.
- Clock-edge update, in priority order:
  - flush: ds_valid <= 0; the incoming instruction is dropped even if offered.
  - else if ds_allowin: ds_valid <= fs_to_ds_valid.
  - if fs_to_ds_valid & ds_allowin & ~flush: ds_inst <= fs_inst and ds_pc <= fs_pc.
- Backpressure (ds_valid & ~es_allowin): held bundle and outputs stay stable; fetch input is ignored.
- A same-cycle handoff to EX plus accept from fetch sustains 1 instruction/cycle. Latency is 1 cycle from accept to ds_to_es_valid.
- Reset asserted mid-operation clears state immediately (asynchronous); the held instruction is lost.
- Decode is combinational from ds_inst; rf_raddr1 = ds_inst[25:21], rf_raddr2 = ds_inst[20:16].
- alu_op mapping:
  - add: addu, add, addiu, addi, lw, sw
  - sub: subu, sub
  - slt: slt, slti
  - sltu: sltu, sltiu
  - and: and, andi
  - or: or, ori
  - xor: xor, xori
  - nor: nor
  - sll: sll, sllv
  - srl: srl, srlv
  - sra: sra, srav
  - lui: lui
  - Exactly one bit is set for a valid instruction.
- alu_src1:
  - sll/srl/sra (immediate shifts): {27'b0, sa}.
  - All others: rs_value. Variable shifts use rs_value, and EX uses only bits [4:0].
- alu_src2:
  - addi/addiu/slti/sltiu/lw/sw: sign-extended imm16.
  - andi/ori/xori: zero-extended imm16.
  - lui: {16'b0, imm16}.
  - All others: rt_value.
- dest:
  - R-type: rd.
  - I-type ALU, lui, lw: rt.
  - sw: 0.
- ov_en = 1 only for add, addi, sub.
- Unrecognised opcode/funct: inst_invalid=1, alu_op=0, dest=0, ov_en=0; ds_to_es_valid still asserts so EX can raise the exception.
- sll $0,$0,0 (nop, 0x00000000) decodes as sll with dest=0 and inst_invalid=0.

Test Plan:
- Sign-extended immediate. Stimulus: offer addiu $2,$1,-4 (0x2422FFFC), rs_value=0x00000010, es_allowin=1. Required next cycle: ds_to_es_valid=1, alu_op=0x001, src1=0x10, src2=0xFFFFFFFC, dest=2, ov_en=0.
- Zero-extended immediate. Stimulus: ori $3,$0,0x8000 (0x34038000). Required: alu_op=0x040, src2=0x00008000, dest=3. Then lui $3,0x1234 (0x3C031234): alu_op=0x800, src2=0x00001234.
- Immediate shift. Stimulus: sra $4,$5,3 (0x000520C3), rt_value=0x80000000. Required: alu_op=0x400, src1=0x00000003, src2=0x80000000, dest=4.
- Backpressure. Stimulus: hold es_allowin=0 for 3 cycles with an instruction held and fetch offering a new one. Required: ds_allowin=0 and all outputs constant throughout. Then set es_allowin=1. Required: new instruction appears the following cycle, with no loss or duplication.
- Flush/reset priority. Stimulus: flush together with fs_to_ds_valid. Required: ds_to_es_valid=0 next cycle. Stimulus: drop resetn asynchronously mid-stream. Required: all outputs 0 immediately, without waiting for a clock edge.
- Invalid instruction. Stimulus: 0xFC000000. Required: ds_to_es_valid=1, inst_invalid=1, alu_op=0, dest=0.
